nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Sequences a single 4-bit ripple-carry adder slice to add or subtract two wide operands, one nibble per clock, LSB nibble first.
- The carry is held in a register between nibbles.
- Used in the neural-network accumulation path where wide sums are needed but LUT budget favours one shared 4-bit slice.
- Valid/ready handshake on input and output; one operation in flight at a time.

Parameters:
- NIBBLES, 4, operand width in nibbles (operand width W = 4*NIBBLES); legal range 2..16.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept an operation (high only in IDLE)
- a  input  W  operand A
- b  input  W  operand B
- sub  input  1  0: A+B, 1: A-B (two's complement)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  W  result
- cout  output  1  final carry out (for sub: 1 = no borrow)
- overflow  output  1  signed overflow of the W-bit operation

Behaviour:
- Reset (synchronous, active-high) is applied on any rising edge with rst=1 and dominates all other inputs.
  - Reset state: IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, idx=0, carry=0.
  - Reset mid-RUN or mid-DONE discards the operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, capture a, b, sub into registers; set carry<=sub, idx<=0, clear the result register; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: nibble_sum, c = a[idx] + (b[idx] ^ {4{sub_r}}) + carry.
  - Write nibble_sum into result nibble idx; carry<=c; idx<=idx+1.
  - When idx==NIBBLES-1, go to DONE and latch cout<=c.
  - Latch overflow <= (a_msb == b_eff_msb) && (nibble_sum[3] != a_msb), where b_eff is B after the sub inversion.
- DONE:
  - out_valid=1; sum, cout and overflow are stable and registered.
  - in_ready=0; in_valid is ignored.
  - On out_ready=1, go to IDLE (out_valid drops the next cycle).
- Latency:
  - Accept edge E0, then NIBBLES RUN edges; out_valid is high from edge E_NIBBLES.
  - Minimum initiation interval is NIBBLES+2 cycles (accept, N RUN, one DONE handshake cycle).
- Outputs hold their last values in IDLE until the next DONE. out_valid alone qualifies them.
- idx width is clog2(NIBBLES). idx wraps only via reset to 0 on accept and never exceeds NIBBLES-1.
- Simultaneous in_valid and out_ready in DONE: the result is consumed; the new operand is not accepted until IDLE.
- sub=1 with b=0: carry-in of 1 plus inverted zeros gives a=a, cout=1.

Decomposition:
- Shared package/header:
  - NIB_W=4.
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - clog2 function for the idx width.
- One natural sub-module: nibble_add_cin.
  - Purely combinational 4-bit ripple adder with explicit carry-in.
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout.
  - Instantiated once and fed by nibble muxes indexed by idx.
- The controller holds only the FSM, operand/result registers, the carry register and the index counter.

Test Plan (NIBBLES=4):
- Add, 0x1234+0x0FFF, sub=0 -> sum=0x2233, cout=0, overflow=0; out_valid high exactly 4 cycles after the accept edge.
- Full carry ripple, 0xFFFF+0x0001 -> sum=0x0000, cout=1, overflow=0.
- Signed overflow, 0x7FFF+0x0001 -> sum=0x8000, cout=0, overflow=1.
- Subtract with borrow, 0x0005-0x0007 (sub=1) -> sum=0xFFFE, cout=0, overflow=0. Also 0x8000-0x0001 -> sum=0x7FFF, overflow=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid -> out_valid, sum and cout stay constant, in_ready=0, no new capture. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst for 1 cycle after 2 RUN cycles -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0. A subsequent 0x0001+0x0001 yields 0x0002.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants, FSM encoding and width helper for the nibble-serial adder.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width; a floor of 1 keeps the counter legal for the smallest operand.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_add_cin.sv
// Combinational 4-bit ripple-carry slice with explicit carry-in.
module nibble_add_cin
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds or subtracts two wide operands through one shared 4-bit slice, LSB nibble first.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W      = NIB_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int                 IDX_W    = clog2(NIBBLES);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic             sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NIB_W-1:0] nib_a, nib_b, nib_sum;
  logic             nib_cout;

  // B is inverted nibble by nibble; the +1 of two's complement enters as the initial carry.
  assign nib_a = a_q[idx_q*NIB_W +: NIB_W];
  assign nib_b = b_q[idx_q*NIB_W +: NIB_W] ^ {NIB_W{sub_q}};

  nibble_add_cin u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          idx_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[idx_q*NIB_W +: NIB_W] = nib_sum;
        carry_d = nib_cout;
        if (idx_q == IDX_LAST) begin
          // Top nibble: its sign bits decide signed overflow; idx parks at the last nibble.
          cout_d  = nib_cout;
          ovf_d   = (nib_a[NIB_W-1] == nib_b[NIB_W-1]) && (nib_sum[NIB_W-1] != nib_a[NIB_W-1]);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at NIBBLES=4: vector table plus handshake/reset sequences.
module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, out_valid, out_ready, cout, overflow;
  logic [W-1:0] a, b, sum;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[7];

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept an operation and wait for out_valid; returns edges counted after the accept edge.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                       output int lat);
    a        = va;
    b        = vb;
    sub      = vs;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("retire_in_ready", 32'(in_ready), 32'd1);
    chk("retire_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_sum;
    logic         held_cout;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      retire();
    end

    // Backpressure in DONE with in_valid pulsing on different operands.
    issue(16'h1234, 16'h0FFF, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    held_sum  = sum;
    held_cout = cout;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      step();
      chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_sum", k), 32'(sum), 32'(held_sum));
      chk($sformatf("bp%0d_cout", k), 32'(cout), 32'(held_cout));
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_exit_in_ready", 32'(in_ready), 32'd1);
    chk("bp_exit_out_valid", 32'(out_valid), 32'd0);
    step();
    chk("bp_no_capture", 32'(in_ready), 32'd1);

    // Reset after two RUN edges discards the operation.
    a = 16'hFFFF; b = 16'h0001; sub = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    issue(16'h0001, 16'h0001, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_sum", 32'(sum), 32'h0002);
    chk("post_rst_cout", 32'(cout), 32'd0);
    retire();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
